// File: rtl/trans_ascii_fmt.sv
// trans_ascii_fmt: converts one binary sensor reading into a framed ASCII line
// and streams it out one byte at a time over a valid/ready interface.
//
// Frame: ' ', 4-char label, ':', N_DIGITS decimal digits (MSB first),
//        2-char unit, optional 0x0D, 0x0A.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   start          one-cycle request; samples data and ch when idle
//   data [DATA_W]  unsigned reading
//   ch   [2]       channel: 0 DIST/CM, 1 TEMP/ C, 2 HUMI/ %, 3 TIME/ S
//   tx_data [8]    ASCII byte (registered)
//   tx_valid       tx_data valid (registered)
//   tx_ready       sink accepts the byte this cycle
//   busy           conversion or frame in progress
//   drop           one-cycle pulse: start ignored because busy
module trans_ascii_fmt #(
  parameter int DATA_W   = 9,
  parameter int N_DIGITS = 3,
  parameter int LZ_BLANK = 0,
  parameter int EOL_CRLF = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        ch,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              drop
);

  // The BCD accumulator always holds 10 digits so that readings too wide for
  // N_DIGITS are detectable as overflow.
  localparam int BCD_W = 40;
  localparam int F     = N_DIGITS + 9 + EOL_CRLF;
  localparam int IDX_W = $clog2(F + 1);
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_EMIT} state_t;

  state_t            state_q, state_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [1:0]        ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              drop_q, drop_d;

  // One double-dabble iteration: correct every nibble >= 5, then shift the
  // combined {bcd, bin} register left by one.
  function automatic logic [BCD_W+DATA_W-1:0] dd_step(input logic [BCD_W-1:0]  b,
                                                      input logic [DATA_W-1:0] v);
    logic [BCD_W-1:0] a;
    a = b;
    for (int d = 0; d < 10; d++) begin
      if (a[4*d +: 4] >= 4'd5) a[4*d +: 4] = a[4*d +: 4] + 4'd3;
    end
    return {a[BCD_W-2:0], v, 1'b0};
  endfunction

  // Byte at frame position i, given the finished BCD value and channel.
  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] i,
                                            input logic [BCD_W-1:0] b,
                                            input logic [1:0]       c);
    int          ii, didx;
    logic        ovf, lead;
    logic [31:0] lbl;
    logic [15:0] unit;
    logic [7:0]  r;
    ii = int'(i);
    case (c)
      2'd0:    begin lbl = "DIST"; unit = "CM"; end
      2'd1:    begin lbl = "TEMP"; unit = " C"; end
      2'd2:    begin lbl = "HUMI"; unit = " %"; end
      default: begin lbl = "TIME"; unit = " S"; end
    endcase
    ovf = 1'b0;
    for (int d = N_DIGITS; d < 10; d++) begin
      if (b[4*d +: 4] != 4'd0) ovf = 1'b1;
    end
    r = 8'h0A;
    if (ii == 0) begin
      r = 8'h20;
    end else if (ii <= 4) begin
      r = lbl[8*(4-ii) +: 8];
    end else if (ii == 5) begin
      r = 8'h3A;
    end else if (ii < 6 + N_DIGITS) begin
      didx = N_DIGITS - 1 - (ii - 6);
      // Blank only while every digit from the top down to this one is zero;
      // the units digit is never blanked.
      lead = (LZ_BLANK != 0) && (didx != 0);
      for (int p = 0; p < N_DIGITS; p++) begin
        if (p >= didx && b[4*p +: 4] != 4'd0) lead = 1'b0;
      end
      if (ovf)       r = 8'h23;
      else if (lead) r = 8'h20;
      else           r = {4'h3, b[4*didx +: 4]};
    end else if (ii == 6 + N_DIGITS) begin
      r = unit[15:8];
    end else if (ii == 7 + N_DIGITS) begin
      r = unit[7:0];
    end else if (ii == 8 + N_DIGITS && EOL_CRLF != 0) begin
      r = 8'h0D;
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    ch_d       = ch_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    drop_d     = start && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bcd_d   = '0;
          bin_d   = data;
          ch_d    = ch;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        // After DATA_W steps the BCD value is final; the first byte is
        // presented one cycle later.
        if (cnt_q == CNT_W'(DATA_W)) begin
          state_d    = S_EMIT;
          idx_d      = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = frame_byte('0, bcd_q, ch_q);
        end else begin
          {bcd_d, bin_d} = dd_step(bcd_q, bin_q);
          cnt_d          = cnt_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (tx_valid_q && tx_ready) begin
          if (idx_q == IDX_W'(F - 1)) begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
            busy_d     = 1'b0;
            idx_d      = '0;
          end else begin
            idx_d     = idx_q + 1'b1;
            tx_data_d = frame_byte(idx_q + 1'b1, bcd_q, ch_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bcd_q      <= '0;
      bin_q      <= '0;
      ch_q       <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign drop     = drop_q;

endmodule

// File: tb/tb_trans_ascii_fmt.sv
// Testbench for trans_ascii_fmt: three instances with different digit count,
// blanking and end-of-line settings, driven with directed and random frames
// and compared against a decimal-arithmetic reference model.
module tb_trans_ascii_fmt;

  logic       clk = 1'b0;
  logic       rst;
  logic       start    [3];
  logic [8:0] data     [3];
  logic [1:0] ch       [3];
  logic [7:0] tx_data  [3];
  logic       tx_valid [3];
  logic       tx_ready [3];
  logic       busy     [3];
  logic       drop     [3];

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  // u0: 3 digits, no blanking, LF; u1: 3 digits, blanking; u2: 2 digits, CRLF
  trans_ascii_fmt #(.DATA_W(9), .N_DIGITS(3), .LZ_BLANK(0), .EOL_CRLF(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .data(data[0]), .ch(ch[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .busy(busy[0]), .drop(drop[0]));
  trans_ascii_fmt #(.DATA_W(9), .N_DIGITS(3), .LZ_BLANK(1), .EOL_CRLF(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .data(data[1]), .ch(ch[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .busy(busy[1]), .drop(drop[1]));
  trans_ascii_fmt #(.DATA_W(9), .N_DIGITS(2), .LZ_BLANK(0), .EOL_CRLF(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .data(data[2]), .ch(ch[2]),
    .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .busy(busy[2]), .drop(drop[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nd_of(input int u);
    return (u == 2) ? 2 : 3;
  endfunction

  function automatic string label_of(input int c);
    case (c)
      0:       return "DIST";
      1:       return "TEMP";
      2:       return "HUMI";
      default: return "TIME";
    endcase
  endfunction

  function automatic string unit_of(input int c);
    case (c)
      0:       return "CM";
      1:       return " C";
      2:       return " %";
      default: return " S";
    endcase
  endfunction

  // Expected frame computed directly from the decimal value.
  task automatic build_exp(input int u, input int v, input int c);
    int     nd, p;
    longint lim, pw;
    string  lb, un;
    nd = nd_of(u);
    lb = label_of(c);
    un = unit_of(c);
    exp_q.delete();
    exp_q.push_back(8'h20);
    for (int k = 0; k < 4; k++) exp_q.push_back(lb[k]);
    exp_q.push_back(8'h3A);
    lim = 1;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    for (int j = 0; j < nd; j++) begin
      p  = nd - 1 - j;
      pw = 1;
      for (int k = 0; k < p; k++) pw = pw * 10;
      if (v >= lim)                       exp_q.push_back(8'h23);
      else if (u == 1 && p > 0 && v < pw) exp_q.push_back(8'h20);
      else                                exp_q.push_back(8'h30 + 8'((v / pw) % 10));
    end
    exp_q.push_back(un[0]);
    exp_q.push_back(un[1]);
    if (u == 2) exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic do_start(input int u, input int v, input int c);
    data[u]  = 9'(v);
    ch[u]    = 2'(c);
    start[u] = 1'b1;
    tick();
    start[u] = 1'b0;
    chk("busy_after_start", 32'(busy[u]), 32'd1);
    chk("valid_during_conv", 32'(tx_valid[u]), 32'd0);
    build_exp(u, v, c);
  endtask

  task automatic wait_valid(input int u, input int done);
    int n;
    n = done;
    while (!tx_valid[u] && n < 200) begin
      tick();
      n++;
    end
    chk("first_valid_latency", 32'(n), 32'd10);
  endtask

  // bp: 0 = always ready, 1 = random stalls, 2 = random stalls plus a
  // 5-cycle stall while byte index 6 is offered.
  task automatic collect(input int u, input int bp);
    logic [7:0] got[$];
    int         guard, stall;
    logic       pv, pr, v, r;
    logic [7:0] pd, d;
    guard = 0; stall = 0; pv = 1'b0; pr = 1'b1; pd = 8'h00;
    while (got.size() < exp_q.size() && guard < 3000) begin
      v = tx_valid[u];
      d = tx_data[u];
      if (pv && !pr) chk("hold_under_stall", {23'd0, v, d}, {23'd0, 1'b1, pd});
      r = 1'b1;
      if (bp != 0 && $urandom_range(0, 2) == 0) r = 1'b0;
      if (bp == 2 && got.size() == 6 && stall < 5) begin
        r = 1'b0;
        stall++;
        chk("stalled_byte", 32'(d), 32'(exp_q[6]));
      end
      tx_ready[u] = r;
      if (v && r) got.push_back(d);
      pv = v; pr = r; pd = d;
      tick();
      guard++;
    end
    tx_ready[u] = 1'b1;
    chk("frame_len", 32'(got.size()), 32'(exp_q.size()));
    chk("valid_after_frame", 32'(tx_valid[u]), 32'd0);
    chk("busy_after_frame", 32'(busy[u]), 32'd0);
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("byte%0d", i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  task automatic frame(input int u, input int v, input int c, input int bp);
    do_start(u, v, c);
    wait_valid(u, 0);
    collect(u, bp);
  endtask

  task automatic quiet(input int u, input int cycles, input string tag);
    int extra;
    extra = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (tx_valid[u]) extra++;
    end
    chk(tag, 32'(extra), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      start[u] = 1'b0; data[u] = '0; ch[u] = '0; tx_ready[u] = 1'b1;
    end
    tick();
    tick();
    for (int u = 0; u < 3; u++) begin
      chk("rst_valid", 32'(tx_valid[u]), 32'd0);
      chk("rst_data", 32'(tx_data[u]), 32'd0);
      chk("rst_busy", 32'(busy[u]), 32'd0);
      chk("rst_drop", 32'(drop[u]), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Directed frames
    frame(0, 123, 0, 0);
    frame(0, 7, 1, 0);
    frame(1, 7, 1, 0);
    frame(1, 0, 1, 0);
    frame(2, 100, 2, 0);
    frame(2, 99, 2, 0);
    frame(0, 511, 3, 0);

    // Backpressure with a long stall on the first digit
    frame(0, 456, 0, 2);

    // Start while busy is dropped and does not disturb the frame
    do_start(0, 250, 3);
    tick();
    tick();
    data[0] = 9'(999);
    ch[0] = 2'd1;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("drop_pulse", 32'(drop[0]), 32'd1);
    tick();
    chk("drop_clear", 32'(drop[0]), 32'd0);
    wait_valid(0, 4);
    collect(0, 1);
    quiet(0, 30, "no_second_frame");

    // Reset mid-frame at byte index 4
    do_start(0, 123, 0);
    wait_valid(0, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("byte4_offered", 32'(tx_data[0]), 32'(exp_q[4]));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", 32'(tx_valid[0]), 32'd0);
    chk("rst_mid_busy", 32'(busy[0]), 32'd0);
    quiet(0, 20, "no_bytes_after_rst");
    frame(0, 88, 1, 0);

    // Random back-to-back frames with random stalls
    for (int it = 0; it < 12; it++) begin
      int u, v, c, bp;
      u  = int'($urandom_range(0, 2));
      v  = int'($urandom_range(0, 511));
      c  = int'($urandom_range(0, 3));
      bp = int'($urandom_range(0, 1));
      frame(u, v, c, bp);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
